// File: rtl/icache_control_nway.sv
// N-way set-associative instruction-cache controller.
// Arbitrates fetch lookups, line fills from physical memory and full-cache
// flushes. Victim is the lowest invalid way, otherwise the tree-PLRU choice.
module icache_control_nway #(
  parameter int unsigned WAYS     = 4,
  parameter int unsigned SET_BITS = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                mem_read,
  input  logic                flush,
  input  logic [WAYS-1:0]     way_hit,
  input  logic [WAYS-1:0]     way_valid,
  input  logic [WAYS-2:0]     plru_in,
  input  logic                pmem_resp,
  output logic                pmem_read,
  output logic                mem_resp,
  output logic                read_data,
  output logic [WAYS-1:0]     load_data,
  output logic [WAYS-1:0]     load_tag,
  output logic [WAYS-1:0]     set_valid,
  output logic                clear_valid,
  output logic [SET_BITS-1:0] flush_idx,
  output logic                load_plru,
  output logic [WAYS-2:0]     plru_out,
  output logic                stall,
  output logic                flush_busy
);

  localparam int unsigned WB = (WAYS > 2) ? $clog2(WAYS) : 1;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    FILL,
    FILL_DONE,
    FLUSH
  } state_t;

  state_t              state, state_nx;
  logic                flush_pend;
  logic [WB-1:0]       victim_q;
  logic [WB-1:0]       hit_idx;
  logic [WB-1:0]       inv_idx;
  logic [WB-1:0]       plru_victim;
  logic                any_hit;
  logic                any_invalid;
  logic [WAYS-1:0]     plru_ext;
  logic [WAYS-2:0]     plru_upd;
  logic [WAYS-1:0]     victim_oh;

  assign any_hit     = |way_hit;
  assign any_invalid = ~&way_valid;
  assign plru_ext    = {1'b0, plru_in};
  assign victim_oh   = WAYS'(1) << victim_q;

  // Lowest-index hit way and lowest-index invalid way (priority encoders).
  always_comb begin
    hit_idx = '0;
    inv_idx = '0;
    for (int unsigned i = WAYS; i > 0; i--) begin
      if (way_hit[i-1])    hit_idx = WB'(i - 1);
      if (!way_valid[i-1]) inv_idx = WB'(i - 1);
    end
  end

  // Tree-PLRU victim: walk from the root, each bit picks lower (0) or upper (1) half.
  always_comb begin
    int unsigned node;
    logic        b;
    plru_victim = '0;
    node        = 0;
    for (int unsigned l = 0; l < WB; l++) begin
      b                   = plru_ext[node];
      plru_victim[WB-1-l] = b;
      node                = 2 * node + 1 + {31'd0, b};
    end
  end

  // PLRU update: every node on the hit way's path points away from that way.
  always_comb begin
    int unsigned node;
    logic        b;
    plru_upd = plru_in;
    node     = 0;
    for (int unsigned l = 0; l < WB; l++) begin
      b              = hit_idx[WB-1-l];
      plru_upd[node] = ~b;
      node           = 2 * node + 1 + {31'd0, b};
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Flush sweep index, pending-flush flag and registered victim way.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flush_idx  <= '0;
      flush_pend <= 1'b0;
      victim_q   <= '0;
    end else begin
      if (state == FLUSH) flush_idx <= flush_idx + 1'b1;
      // A pulse outside IDLE/FLUSH is remembered until the next IDLE cycle.
      if (state == IDLE && (flush_pend || flush))
        flush_pend <= 1'b0;
      else if (flush && state != IDLE && state != FLUSH)
        flush_pend <= 1'b1;
      if (state == LOOKUP && !any_hit)
        victim_q <= any_invalid ? inv_idx : plru_victim;
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_nx    = state;
    pmem_read   = 1'b0;
    mem_resp    = 1'b0;
    read_data   = 1'b0;
    load_data   = '0;
    load_tag    = '0;
    set_valid   = '0;
    clear_valid = 1'b0;
    load_plru   = 1'b0;
    plru_out    = '0;
    stall       = 1'b0;
    flush_busy  = 1'b0;
    unique case (state)
      IDLE: begin
        read_data = mem_read;
        if (flush_pend || flush) state_nx = FLUSH;
        else if (mem_read)       state_nx = LOOKUP;
      end
      LOOKUP: begin
        if (any_hit) begin
          mem_resp  = 1'b1;
          load_plru = 1'b1;
          plru_out  = plru_upd;
          state_nx  = IDLE;
        end else begin
          pmem_read = 1'b1;
          stall     = 1'b1;
          state_nx  = FILL;
        end
      end
      FILL: begin
        stall = 1'b1;
        if (pmem_resp) begin
          load_data = victim_oh;
          load_tag  = victim_oh;
          set_valid = victim_oh;
          read_data = 1'b1;
          state_nx  = FILL_DONE;
        end else begin
          pmem_read = 1'b1;
        end
      end
      FILL_DONE: begin
        stall    = 1'b1;
        state_nx = LOOKUP;
      end
      FLUSH: begin
        clear_valid = 1'b1;
        load_plru   = 1'b1;
        stall       = 1'b1;
        flush_busy  = 1'b1;
        if (&flush_idx) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule
